// File: rtl/vote_session_machine.sv
// Voting session controller: collects one ballot per voter, then
// registers a reject/tie/pass verdict with yes and abstain counts.
module vote_session_machine #(
  parameter int N_VOTERS    = 4,
  parameter int TIMEOUT_CYC = 255,
  localparam int CW = $clog2(N_VOTERS + 1),
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  input  logic                close,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic [CW-1:0]       yes_cnt,
  output logic [CW-1:0]       abstain_cnt,
  output logic [2:0]          result,
  output logic                result_valid,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    HOLD
  } state_t;

  localparam logic [2:0] RES_REJECT = 3'b100;
  localparam logic [2:0] RES_TIE    = 3'b010;
  localparam logic [2:0] RES_PASS   = 3'b001;

  localparam logic [CW:0]   NV_W    = (CW + 1)'(N_VOTERS);
  localparam logic [CW-1:0] NV_C    = CW'(N_VOTERS);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);

  function automatic logic [CW-1:0] popcnt(
    input logic [N_VOTERS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CW-1:0]       tally_q, tally_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CW-1:0]       yes_cnt_q, yes_cnt_d;
  logic [CW-1:0]       abstain_cnt_q, abstain_cnt_d;
  logic [2:0]          result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                done_q, done_d;

  logic [N_VOTERS-1:0] new_cast;
  logic [N_VOTERS-1:0] voted_nxt;
  logic [CW:0]         yes_x2;
  logic [2:0]          verdict;
  logic                close_cond;

  // only first ballot per voter counts
  assign new_cast  = vote_valid & ~voted_q;
  assign voted_nxt = voted_q | new_cast;

  assign close_cond = close
                    | (&voted_nxt)
                    | (timer_q == T_LAST);

  assign yes_x2 = {tally_q, 1'b0};

  always_comb begin
    verdict = RES_REJECT;
    if (yes_x2 > NV_W) begin
      verdict = RES_PASS;
    end else if (yes_x2 == NV_W) begin
      verdict = RES_TIE;
    end
  end

  always_comb begin
    state_d        = state_q;
    voted_d        = voted_q;
    tally_d        = tally_q;
    timer_d        = timer_q;
    yes_cnt_d      = yes_cnt_q;
    abstain_cnt_d  = abstain_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;
    unique case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d        = COLLECT;
          voted_d        = '0;
          tally_d        = '0;
          timer_d        = '0;
          result_valid_d = 1'b0;
        end
      end
      COLLECT: begin
        voted_d = voted_nxt;
        tally_d = tally_q + popcnt(new_cast & vote_val);
        timer_d = timer_q + 1'b1;
        if (close_cond) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        state_d        = HOLD;
        result_d       = verdict;
        yes_cnt_d      = tally_q;
        abstain_cnt_d  = NV_C - popcnt(voted_q);
        result_valid_d = 1'b1;
        done_d         = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      voted_q        <= '0;
      tally_q        <= '0;
      timer_q        <= '0;
      yes_cnt_q      <= '0;
      abstain_cnt_q  <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      voted_q        <= voted_d;
      tally_q        <= tally_d;
      timer_q        <= timer_d;
      yes_cnt_q      <= yes_cnt_d;
      abstain_cnt_q  <= abstain_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign busy         = (state_q == COLLECT)
                      | (state_q == DECIDE);
  assign voted        = voted_q;
  assign yes_cnt      = yes_cnt_q;
  assign abstain_cnt  = abstain_cnt_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vote_session_machine.sv
// Bench for vote_session_machine: directed sessions on a 4-voter and
// a 5-voter instance, verdicts checked by a done-driven scoreboard.
module tb_vote_session_machine;

  typedef struct packed {
    logic [2:0] res;
    logic [2:0] yes;
    logic [2:0] abst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start = 1'b0;
  logic [3:0] vv = '0;
  logic [3:0] vl = '0;
  logic       cls = 1'b0;
  logic       busy, rv, done;
  logic [3:0] voted;
  logic [2:0] yes_cnt, abst_cnt, result;

  logic       start5 = 1'b0;
  logic [4:0] vv5 = '0;
  logic [4:0] vl5 = '0;
  logic       cls5 = 1'b0;
  logic       busy5, rv5, done5;
  logic [4:0] voted5;
  logic [2:0] yes5, abst5, result5;

  int errors = 0;
  int checks = 0;

  exp_t q4[$];
  exp_t q5[$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  vote_session_machine #(.N_VOTERS(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vote_valid(vv), .vote_val(vl), .close(cls),
    .busy(busy), .voted(voted), .yes_cnt(yes_cnt),
    .abstain_cnt(abst_cnt), .result(result),
    .result_valid(rv), .done(done)
  );

  vote_session_machine #(.N_VOTERS(5), .TIMEOUT_CYC(8)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .vote_valid(vv5), .vote_val(vl5), .close(cls5),
    .busy(busy5), .voted(voted5), .yes_cnt(yes5),
    .abstain_cnt(abst5), .result(result5),
    .result_valid(rv5), .done(done5)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_width", {31'd0, done_prev}, 32'd0);
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("result4", {29'd0, result}, {29'd0, e.res});
        chk("yes4", {29'd0, yes_cnt}, {29'd0, e.yes});
        chk("abst4", {29'd0, abst_cnt}, {29'd0, e.abst});
        chk("rv4", {31'd0, rv}, 32'd1);
      end
    end
    if (!rst && done5) begin
      if (q5.size() == 0) begin
        chk("unexpected_done5", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q5.pop_front();
        chk("result5", {29'd0, result5}, {29'd0, e.res});
        chk("yes5", {29'd0, yes5}, {29'd0, e.yes});
        chk("abst5", {29'd0, abst5}, {29'd0, e.abst});
      end
    end
    done_prev = done;
  end

  task automatic step(input logic s, input logic [3:0] v,
                      input logic [3:0] l, input logic c);
    start = s; vv = v; vl = l; cls = c;
    @(posedge clk);
    #1;
    start = 0; vv = '0; vl = '0; cls = 0;
  endtask

  task automatic step5(input logic s, input logic [4:0] v,
                       input logic [4:0] l, input logic c);
    start5 = s; vv5 = v; vl5 = l; cls5 = c;
    @(posedge clk);
    #1;
    start5 = 0; vv5 = '0; vl5 = '0; cls5 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 4'h0, 0);
  endtask

  initial begin
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {29'd0, result}, 32'd0);
    chk("rst_rv", {31'd0, rv}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_yes", {29'd0, yes_cnt}, 32'd0);
    chk("rst_abst", {29'd0, abst_cnt}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // all voted over two cycles -> pass
    step(1, 4'h0, 4'h0, 0);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    chk("s1_voted0", {28'd0, voted}, 32'd0);
    step(0, 4'b0111, 4'b0111, 0);
    chk("s1_voted1", {28'd0, voted}, 32'h7);
    q4.push_back('{3'b001, 3'd3, 3'd0});
    step(0, 4'b1000, 4'b0000, 0);
    chk("s1_decide_busy", {31'd0, busy}, 32'd1);
    chk("s1_decide_done", {31'd0, done}, 32'd0);
    idle(1);
    chk("s1_done", {31'd0, done}, 32'd1);
    chk("s1_idle_busy", {31'd0, busy}, 32'd0);
    idle(1);
    chk("s1_done_pulse", {31'd0, done}, 32'd0);
    chk("s1_hold_rv", {31'd0, rv}, 32'd1);
    step(0, 4'b1111, 4'b1111, 1);
    chk("hold_ignore_votes", {28'd0, voted}, 32'hF);
    chk("hold_result", {29'd0, result}, 32'h1);

    // tie with ignored recast
    step(1, 4'h0, 4'h0, 0);
    chk("s2_rv_clear", {31'd0, rv}, 32'd0);
    chk("s2_voted_clear", {28'd0, voted}, 32'd0);
    chk("s2_result_kept", {29'd0, result}, 32'h1);
    step(0, 4'b0011, 4'b0011, 0);
    step(0, 4'b0001, 4'b0000, 0);
    chk("s2_recast", {28'd0, voted}, 32'h3);
    q4.push_back('{3'b010, 3'd2, 3'd0});
    step(0, 4'b1100, 4'b0000, 0);
    idle(1);
    chk("s2_done", {31'd0, done}, 32'd1);

    // timeout, with start ignored in COLLECT
    step(1, 4'h0, 4'h0, 0);
    step(0, 4'b0100, 4'b0100, 0);
    step(1, 4'h0, 4'h0, 0);
    q4.push_back('{3'b100, 3'd1, 3'd3});
    idle(6);
    chk("s3_pre_done", {31'd0, done}, 32'd0);
    chk("s3_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("s3_done", {31'd0, done}, 32'd1);

    // close with same-cycle ballot
    step(1, 4'h0, 4'h0, 0);
    step(0, 4'b0001, 4'b0001, 0);
    q4.push_back('{3'b010, 3'd2, 3'd2});
    step(0, 4'b0010, 4'b0010, 1);
    idle(1);
    chk("s4_done", {31'd0, done}, 32'd1);

    // reset mid-session
    step(1, 4'h0, 4'h0, 0);
    step(0, 4'b0011, 4'b0011, 0);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_voted", {28'd0, voted}, 32'd0);
    chk("mr_result", {29'd0, result}, 32'd0);
    chk("mr_yes", {29'd0, yes_cnt}, 32'd0);
    chk("mr_abst", {29'd0, abst_cnt}, 32'd0);
    chk("mr_rv", {31'd0, rv}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_no_done", {31'd0, done}, 32'd0);
    step(1, 4'h0, 4'h0, 0);
    q4.push_back('{3'b001, 3'd3, 3'd0});
    step(0, 4'b1111, 4'b1011, 0);
    idle(1);
    chk("s5_done", {31'd0, done}, 32'd1);
    idle(1);

    // restart from HOLD
    step(1, 4'h0, 4'h0, 0);
    chk("s6_rv_clear", {31'd0, rv}, 32'd0);
    chk("s6_voted_clear", {28'd0, voted}, 32'd0);
    q4.push_back('{3'b100, 3'd0, 3'd4});
    step(0, 4'h0, 4'h0, 1);
    idle(2);

    // odd voter count: 2 of 5 yes cannot tie
    step5(1, 5'h0, 5'h0, 0);
    q5.push_back('{3'b100, 3'd2, 3'd0});
    step5(0, 5'b11111, 5'b00011, 0);
    step5(0, 5'h0, 5'h0, 0);
    step5(0, 5'h0, 5'h0, 0);
    step5(1, 5'h0, 5'h0, 0);
    q5.push_back('{3'b001, 3'd3, 3'd2});
    step5(0, 5'b00111, 5'b00111, 1);
    step5(0, 5'h0, 5'h0, 0);
    step5(0, 5'h0, 5'h0, 0);
    step5(1, 5'h0, 5'h0, 0);
    q5.push_back('{3'b100, 3'd1, 3'd3});
    step5(0, 5'b00011, 5'b00001, 1);
    step5(0, 5'h0, 5'h0, 0);
    step5(0, 5'h0, 5'h0, 0);

    chk("q4_drained", q4.size(), 32'd0);
    chk("q5_drained", q5.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
